// File: rtl/eq_band_scheduler_if.sv
// Sample, coefficient-ROM and result signals of the band scheduler.
// Latency: none, signal bundle only.
// Backpressure: none; the scheduler drops samples that arrive while busy.
interface eq_band_scheduler_if;
  logic signed [15:0] sample_in;
  logic               sample_valid;
  logic        [7:0]  coef_addr;
  logic signed [15:0] coef_data;
  logic               busy;
  logic               out_valid;
  logic        [1:0]  out_band;
  logic signed [15:0] out_data;
  logic               overrun;

  // Sample source and coefficient ROM side
  modport master (
    output sample_in, sample_valid, coef_data,
    input  coef_addr, busy, out_valid, out_band, out_data, overrun
  );

  // Scheduler side
  modport slave (
    input  sample_in, sample_valid, coef_data,
    output coef_addr, busy, out_valid, out_band, out_data, overrun
  );
endinterface

// File: rtl/eq_band_scheduler.sv
// Multi-band FIR equalizer: one shared 16x16 MAC runs TAPS taps per band over a circular delay line.
// Latency: band b result strobes 60+60*b cycles after the accepting sample_valid (TAPS=57); idle again after the last band.
// Backpressure: none; a sample_valid while busy is dropped and sets the sticky overrun flag.
module eq_band_scheduler #(
  parameter int TAPS  = 57,
  parameter int BANDS = 3,
  parameter int FRAC  = 14
) (
  input logic                 clock_50,
  input logic                 reset,
  eq_band_scheduler_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] MAC   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [5:0] LAST_TAP  = 6'(TAPS - 1);
  localparam logic [5:0] NTAPS     = 6'(TAPS);
  localparam logic [1:0] LAST_BAND = 2'(BANDS - 1);

  logic        [1:0]  state;
  logic        [1:0]  band;
  logic        [5:0]  tap;
  logic               drain_cnt;
  logic signed [15:0] dline [TAPS];
  logic        [5:0]  wr_ptr;
  logic        [5:0]  newest;
  logic        [5:0]  rd_idx;
  logic signed [15:0] tap_sample;
  logic               tap_vld;
  logic signed [31:0] product;
  logic               prod_vld;
  logic signed [39:0] acc;
  logic signed [39:0] acc_sh;
  logic signed [15:0] sat_val;
  logic        [7:0]  addr_hold;
  logic signed [15:0] out_hold;
  logic        [1:0]  band_hold;
  logic               overrun_r;
  logic               accept;

  assign accept = (state == IDLE) && bus.sample_valid;

  // Tap k lives k slots behind the newest entry, wrapping around the ring
  always_comb begin
    rd_idx = '0;
    if (newest >= tap) rd_idx = newest - tap;
    else               rd_idx = newest + NTAPS - tap;
  end

  // Scale back from Q2.14 products and clamp to the 16-bit output range
  assign acc_sh = acc >>> FRAC;
  always_comb begin
    sat_val = acc_sh[15:0];
    if (acc_sh > 40'sd32767)       sat_val = 16'sh7fff;
    else if (acc_sh < -40'sd32768) sat_val = 16'sh8000;
  end

  // Sequencer: per band, TAPS MAC cycles, 2 pipeline drain cycles, 1 output cycle
  always_ff @(posedge clock_50) begin
    if (reset) begin
      state     <= IDLE;
      band      <= '0;
      tap       <= '0;
      drain_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.sample_valid) begin
            state <= MAC;
            band  <= '0;
            tap   <= '0;
          end
        end
        MAC: begin
          if (tap == LAST_TAP) begin
            state     <= DRAIN;
            drain_cnt <= 1'b0;
          end else begin
            tap <= tap + 6'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt) state <= OUT;
          else           drain_cnt <= 1'b1;
        end
        default: begin
          if (band < LAST_BAND) begin
            band  <= band + 2'd1;
            tap   <= '0;
            state <= MAC;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Delay line: accepted samples overwrite the oldest slot
  always_ff @(posedge clock_50) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) dline[i] <= '0;
      wr_ptr <= '0;
      newest <= '0;
    end else if (accept) begin
      dline[wr_ptr] <= bus.sample_in;
      newest        <= wr_ptr;
      wr_ptr        <= (wr_ptr == LAST_TAP) ? 6'd0 : wr_ptr + 6'd1;
    end
  end

  // MAC pipeline: sample read lines up with ROM data, product registered, then accumulated
  always_ff @(posedge clock_50) begin
    if (reset) begin
      tap_vld    <= 1'b0;
      tap_sample <= '0;
      prod_vld   <= 1'b0;
      product    <= '0;
      acc        <= '0;
    end else begin
      tap_vld    <= (state == MAC);
      tap_sample <= dline[rd_idx];
      prod_vld   <= tap_vld;
      product    <= tap_sample * $signed(bus.coef_data);
      if (accept || (state == OUT))
        acc <= '0;
      else if (prod_vld)
        acc <= acc + $signed({{8{product[31]}}, product});
    end
  end

  // Held outputs and sticky overrun
  always_ff @(posedge clock_50) begin
    if (reset) begin
      addr_hold <= '0;
      out_hold  <= '0;
      band_hold <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (state == MAC) addr_hold <= {band, tap};
      if (state == OUT) begin
        out_hold  <= sat_val;
        band_hold <= band;
      end
      if (bus.sample_valid && (state != IDLE)) overrun_r <= 1'b1;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = (state == OUT);
  assign bus.out_data  = (state == OUT) ? sat_val : out_hold;
  assign bus.out_band  = (state == OUT) ? band : band_hold;
  assign bus.coef_addr = (state == MAC) ? {band, tap} : addr_hold;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_eq_band_scheduler.sv
// Bench for eq_band_scheduler: reference FIR model feeds a scoreboard of expected band results.
// Latency: results checked against the exact cycle they are due.
// Backpressure: overrun and reset-abort scenarios exercised directly.
module tb_eq_band_scheduler;
  logic clock_50 = 1'b0;
  logic reset;

  eq_band_scheduler_if bus();

  eq_band_scheduler dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clock_50 = ~clock_50;

  int cyc = 0;
  always @(posedge clock_50) cyc <= cyc + 1;

  // Coefficient ROM with one cycle of read latency
  logic signed [15:0] rom [0:255];
  always @(posedge clock_50) bus.coef_data <= rom[bus.coef_addr];

  typedef struct {
    int                 cyc;
    logic [1:0]         band;
    logic signed [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   hist [57];
  int   total = 0;
  int   bad   = 0;
  logic signed [15:0] last_b0 = '0;

  // Scoreboard: every result strobe is popped and compared against the model
  always @(negedge clock_50) begin
    if (bus.out_valid === 1'b1) begin
      total++;
      if (bus.out_band == 2'd0) last_b0 = bus.out_data;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result cyc=%0d band=%0d data=%0d, required no result", cyc, bus.out_band, bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (cyc !== mon_e.cyc || bus.out_band !== mon_e.band || bus.out_data !== mon_e.data) begin
          bad++;
          $display("FAIL result cyc=%0d band=%0d data=%0d, required cyc=%0d band=%0d data=%0d",
                   cyc, bus.out_band, bus.out_data, mon_e.cyc, mon_e.band, mon_e.data);
        end
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 57; k++) hist[k] = 0;
    exp_q.delete();
  endtask

  task automatic load_rom_ramp();
    for (int a = 0; a < 256; a++) rom[a] = '0;
    for (int b = 0; b < 3; b++)
      for (int k = 0; k < 57; k++) rom[b*64+k] = 16'(100*b + k);
  endtask

  // Drives one sample strobe; called #1 after a posedge, returns #1 after the next one
  task automatic send_sample(input logic signed [15:0] s, input bit accept, output int t);
    bus.sample_in    = s;
    bus.sample_valid = 1'b1;
    t = cyc;
    if (accept) begin
      for (int k = 56; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = s;
      for (int b = 0; b < 3; b++) begin
        longint acc;
        longint sh;
        exp_t   e;
        acc = 0;
        for (int k = 0; k < 57; k++) acc += longint'(hist[k]) * longint'(rom[b*64+k]);
        sh = acc >>> 14;
        if (sh > 32767)  sh = 32767;
        if (sh < -32768) sh = -32768;
        e.cyc  = t + 60 + 60*b;
        e.band = 2'(b);
        e.data = sh[15:0];
        exp_q.push_back(e);
      end
    end
    @(posedge clock_50); #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 400) begin
      @(posedge clock_50); #1;
      n++;
    end
    total++;
    if (n >= 400 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_idle waited=%0d pending=%0d, required idle within 400 cycles with 0 pending", name, n, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'sd777;
    repeat (3) @(posedge clock_50);
    #1;
    bus.sample_valid = 1'b0;
    total += 6;
    if (bus.busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", bus.out_valid); end
    if (bus.out_band !== 2'd0)  begin bad++; $display("FAIL rst_out_band got=%0d want=0", bus.out_band); end
    if (bus.out_data !== 16'sd0) begin bad++; $display("FAIL rst_out_data got=%0d want=0", bus.out_data); end
    if (bus.overrun !== 1'b0)   begin bad++; $display("FAIL rst_overrun got=%b want=0", bus.overrun); end
    if (bus.coef_addr !== 8'd0) begin bad++; $display("FAIL rst_coef_addr got=%0d want=0", bus.coef_addr); end
    reset = 1'b0;
    @(posedge clock_50); #1;
    total += 2;
    if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_valid_ignored busy=%b want=0", bus.busy); end
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL rst_valid_no_overrun got=%b want=0", bus.overrun); end
    clear_model();
  endtask

  task automatic test_impulse();
    int t;
    load_rom_ramp();
    for (int n = 0; n < 57; n++) begin
      send_sample((n == 0) ? 16'sd16384 : 16'sd0, 1'b1, t);
      wait_idle("impulse");
    end
    total += 3;
    if (bus.out_valid !== 1'b0)   begin bad++; $display("FAIL impulse_strobe got=%b want=0", bus.out_valid); end
    if (bus.out_band !== 2'd2)    begin bad++; $display("FAIL impulse_hold_band got=%0d want=2", bus.out_band); end
    if (bus.out_data !== 16'sd256) begin bad++; $display("FAIL impulse_hold_data got=%0d want=256", bus.out_data); end
  endtask

  task automatic test_timing();
    int t;
    send_sample(16'sd1000, 1'b1, t);
    for (int c = t + 1; c <= t + 181; c++) begin
      @(negedge clock_50);
      total++;
      if (bus.busy !== ((c <= t + 180) ? 1'b1 : 1'b0)) begin
        bad++; $display("FAIL timing_busy rel=%0d got=%b want=%b", c - t, bus.busy, (c <= t + 180));
      end
      if (c == t+1 || c == t+57 || c == t+58 || c == t+61 || c == t+180) begin
        logic [7:0] want;
        want = (c == t+1) ? 8'h00 : (c == t+61) ? 8'h40 : (c == t+180) ? 8'hB8 : 8'd56;
        total++;
        if (bus.coef_addr !== want) begin
          bad++; $display("FAIL timing_coef_addr rel=%0d got=%0h want=%0h", c - t, bus.coef_addr, want);
        end
      end
    end
    @(posedge clock_50); #1;
    wait_idle("timing");
  endtask

  task automatic test_saturation();
    int t;
    for (int k = 0; k < 57; k++) rom[k] = 16'sd16384;
    for (int n = 0; n < 57; n++) begin
      send_sample(16'sd32767, 1'b1, t);
      wait_idle("sat_pos");
    end
    total++;
    if (last_b0 !== 16'sd32767) begin bad++; $display("FAIL sat_pos got=%0d want=32767", last_b0); end
    for (int n = 0; n < 57; n++) begin
      send_sample(-16'sd32768, 1'b1, t);
      wait_idle("sat_neg");
    end
    total++;
    if (last_b0 !== -16'sd32768) begin bad++; $display("FAIL sat_neg got=%0d want=-32768", last_b0); end
    load_rom_ramp();
  endtask

  task automatic test_overrun();
    int t;
    int t2;
    send_sample(16'sd500, 1'b1, t);
    repeat (4) begin @(posedge clock_50); #1; end
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_before got=%b want=0", bus.overrun); end
    send_sample(-16'sd500, 1'b0, t2);
    total += 2;
    if (t2 - t !== 5) begin bad++; $display("FAIL overrun_spacing got=%0d want=5", t2 - t); end
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_set got=%b want=1", bus.overrun); end
    wait_idle("overrun");
    send_sample(16'sd2000, 1'b1, t);
    wait_idle("overrun_next");
    total++;
    if (bus.overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky got=%b want=1", bus.overrun); end
    reset = 1'b1;
    @(posedge clock_50); #1;
    reset = 1'b0;
    clear_model();
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL overrun_cleared got=%b want=0", bus.overrun); end
  endtask

  task automatic test_reset_mid();
    int t;
    send_sample(16'sd300, 1'b1, t);
    repeat (99) begin @(posedge clock_50); #1; end
    reset = 1'b1;
    bus.sample_valid = 1'b1;
    bus.sample_in = 16'sd4321;
    @(posedge clock_50); #1;
    reset = 1'b0;
    bus.sample_valid = 1'b0;
    clear_model();
    total += 4;
    if (cyc - t !== 101)        begin bad++; $display("FAIL midrst_cycle got=%0d want=101", cyc - t); end
    if (bus.busy !== 1'b0)      begin bad++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
    if (bus.out_data !== 16'sd0) begin bad++; $display("FAIL midrst_out_data got=%0d want=0", bus.out_data); end
    if (bus.coef_addr !== 8'd0) begin bad++; $display("FAIL midrst_coef_addr got=%0d want=0", bus.coef_addr); end
    repeat (200) begin @(posedge clock_50); #1; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst_quiet busy=%b want=0", bus.busy); end
    send_sample(16'sd16384, 1'b1, t);
    wait_idle("midrst_imp");
    send_sample(16'sd0, 1'b1, t);
    wait_idle("midrst_zero");
    total++;
    if (bus.out_data !== 16'sd201) begin bad++; $display("FAIL midrst_history got=%0d want=201", bus.out_data); end
  endtask

  task automatic test_back_to_back();
    int t;
    int t2;
    send_sample(16'sd7, 1'b1, t);
    repeat (180) begin @(posedge clock_50); #1; end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_at_181 busy=%b want=0", bus.busy); end
    send_sample(16'sd9, 1'b1, t2);
    total += 2;
    if (t2 - t !== 181)    begin bad++; $display("FAIL b2b_spacing got=%0d want=181", t2 - t); end
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accepted busy=%b want=1", bus.busy); end
    wait_idle("b2b");
    total++;
    if (bus.overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b want=0", bus.overrun); end
  endtask

  initial begin
    reset = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    for (int a = 0; a < 256; a++) rom[a] = '0;
    test_reset();
    test_impulse();
    test_timing();
    test_saturation();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
